// File: rtl/mem_io.sv
// CPU-side memory and I/O decoder: byte RAM, reset vector bytes, and a
// first-word fall-through console transmit FIFO with a sticky overflow flag.
module mem_io #(
   parameter int          RAM_AW     = 12,
   parameter logic [15:0] RESET_VEC  = 16'h0200,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  wr_data,
   input  logic        wr_enable,
   output logic [7:0]  rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [15:0] ADDR_TXDATA = 16'hD000;
   localparam logic [15:0] ADDR_STATUS = 16'hD001;
   localparam logic [15:0] ADDR_VEC_LO = 16'hFFFC;
   localparam logic [15:0] ADDR_VEC_HI = 16'hFFFD;

   logic [7:0]    ram  [2**RAM_AW];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic          overflow;

   logic ram_sel, txdata_sel, status_sel;
   logic empty, full, pop, push_req, push, ovf_set, ovf_clr;
   logic [4:0] status_count;

   assign ram_sel    = ((32'(address) >> RAM_AW) == 32'd0);
   assign txdata_sel = (address == ADDR_TXDATA);
   assign status_sel = (address == ADDR_STATUS);

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign tx_valid = !empty;
   assign tx_data  = fifo[head];

   // A pop in the same edge frees a slot, so a push into a full FIFO is
   // accepted only when it coincides with a pop.
   assign pop      = tx_valid && tx_ready;
   assign push_req = wr_enable && txdata_sel;
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = wr_enable && status_sel;

   assign status_count = 5'(count);

   always_comb begin
      rd_data = 8'hFF;
      if (ram_sel)
         rd_data = ram[address[RAM_AW-1:0]];
      else if (txdata_sel)
         rd_data = 8'h00;
      else if (status_sel)
         rd_data = {status_count, overflow, full, empty};
      else if (address == ADDR_VEC_LO)
         rd_data = RESET_VEC[7:0];
      else if (address == ADDR_VEC_HI)
         rd_data = RESET_VEC[15:8];
   end

   // Storage arrays carry no reset; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_enable && ram_sel)
         ram[address[RAM_AW-1:0]] <= wr_data;
      if (!reset && push)
         fifo[tail] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_clr)
            overflow <= 1'b0;
         else if (ovf_set)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io.sv
// Directed bench for mem_io: memory map, RAM, FIFO ordering, overflow,
// full-with-pop and asynchronous reset behaviour.
module tb_mem_io;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] address;
   logic [7:0]  wr_data;
   logic        wr_enable;
   logic [7:0]  rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int checks = 0;
   int errors = 0;

   mem_io dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .wr_data   (wr_data),
      .wr_enable (wr_enable),
      .rd_data   (rd_data),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive a write so that the next rising edge samples it; returns at the following negedge.
   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      address   = a;
      wr_data   = d;
      wr_enable = 1'b1;
      @(negedge clk);
      wr_enable = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check(tag, {8'h00, rd_data}, {8'h00, exp});
   endtask

   initial begin
      reset     = 1'b1;
      address   = 16'h0000;
      wr_data   = 8'h00;
      wr_enable = 1'b0;
      tx_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_valid", {15'd0, tx_valid}, 16'h0000);
      rd("reset_status", 16'hD001, 8'h01);
      reset = 1'b0;
      @(negedge clk);

      // Vector bytes and unmapped space
      rd("vec_lo", 16'hFFFC, 8'h00);
      rd("vec_hi", 16'hFFFD, 8'h02);
      rd("unmapped", 16'h1234, 8'hFF);

      // RAM
      wr(16'h0010, 8'hA5);
      rd("ram_0010", 16'h0010, 8'hA5);
      wr(16'h0FFF, 8'h11);
      wr(16'h1000, 8'h22);
      rd("ram_top", 16'h0FFF, 8'h11);
      rd("ram_above", 16'h1000, 8'hFF);
      wr(16'hFFFC, 8'h5C);
      rd("vec_wr_ignored", 16'hFFFC, 8'h00);
      rd("txdata_read", 16'hD000, 8'h00);

      // FIFO ordering
      wr(16'hD000, 8'h41);
      wr(16'hD000, 8'h42);
      wr(16'hD000, 8'h43);
      rd("status_3", 16'hD001, 8'h18);
      check("head_hold", {8'h00, tx_data}, 16'h0041);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("order_valid", {15'd0, tx_valid}, 16'h0001);
         check("order_data", {8'h00, tx_data}, 16'h0041 + 16'(i));
         @(negedge clk);
      end
      check("drained_valid", {15'd0, tx_valid}, 16'h0000);
      rd("drained_status", 16'hD001, 8'h01);
      tx_ready = 1'b0;

      // Full and overflow
      for (int i = 0; i < 17; i++) wr(16'hD000, 8'(i));
      rd("status_ovf", 16'hD001, 8'h86);
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("ovf_drain", {8'h00, tx_data}, 16'(i));
         @(negedge clk);
      end
      tx_ready = 1'b0;
      rd("ovf_sticky", 16'hD001, 8'h05);
      wr(16'hD001, 8'h00);
      rd("ovf_cleared", 16'hD001, 8'h01);

      // Full with concurrent pop
      for (int i = 0; i < 16; i++) wr(16'hD000, 8'h10 + 8'(i));
      rd("status_full", 16'hD001, 8'h82);
      tx_ready = 1'b1;
      check("full_head", {8'h00, tx_data}, 16'h0010);
      wr(16'hD000, 8'h77);
      rd("full_pop_status", 16'hD001, 8'h82);
      for (int i = 1; i < 16; i++) begin
         #1;
         check("full_pop_data", {8'h00, tx_data}, 16'h0010 + 16'(i));
         @(negedge clk);
      end
      #1;
      check("late_77", {8'h00, tx_data}, 16'h0077);
      check("late_77_valid", {15'd0, tx_valid}, 16'h0001);
      @(negedge clk);
      check("after_77_valid", {15'd0, tx_valid}, 16'h0000);
      tx_ready = 1'b0;

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) wr(16'hD000, 8'hC0 + 8'(i));
      rd("five_status", 16'hD001, 8'h28);
      #1;
      reset = 1'b1;
      #1;
      check("async_valid", {15'd0, tx_valid}, 16'h0000);
      check("async_status", {8'h00, rd_data}, 16'h0001);
      @(negedge clk);
      wr(16'h0010, 8'h5A);
      reset = 1'b0;
      @(negedge clk);
      rd("ram_kept", 16'h0010, 8'hA5);
      wr(16'hD000, 8'h99);
      check("post_reset_valid", {15'd0, tx_valid}, 16'h0001);
      check("post_reset_data", {8'h00, tx_data}, 16'h0099);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_io.md
MEM_IO -- requirements
Module: mem_io

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 12, meaning RAM address width (4096 bytes at $0000-$0FFF).
REQ-002 The block SHALL have parameter RESET_VEC, default 16'h0200, meaning the value returned at $FFFC (LSB) and $FFFD (MSB).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the number of entries in the console transmit FIFO (power of two).
REQ-004 Port: clk  in  1  sole clock, all state on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: address  in  16  CPU bus address, registered by the CPU.
REQ-007 Port: wr_data  in  8  CPU write data.
REQ-008 Port: wr_enable  in  1  write strobe, sampled at rising edge with address/wr_data.
REQ-009 Port: rd_data  out  8  read data, combinational from address.
REQ-010 Port: tx_data  out  8  FIFO head byte.
REQ-011 Port: tx_valid  out  1  FIFO non-empty.
REQ-012 Port: tx_ready  in  1  downstream console accepts tx_data.

Function
REQ-013 Memory map SHALL be: $0000-$0FFF RAM; $D000 TXDATA; $D001 STATUS; $FFFC vector LSB; $FFFD vector MSB; all other addresses unmapped.
REQ-014 Reads SHALL be combinational: rd_data reflects address in the same cycle so the CPU samples it at the next edge; zero-cycle read latency.
REQ-015 RAM read SHALL return the last byte written to that address, including a write at the immediately preceding edge.
REQ-016 RAM write SHALL occur at the rising edge where wr_enable=1 and address is in $0000-$0FFF; wr_enable held high for N cycles SHALL perform N writes.
REQ-017 Reads of $FFFC/$FFFD SHALL return RESET_VEC[7:0]/RESET_VEC[15:8]; writes there SHALL be ignored.
REQ-018 Unmapped reads SHALL return 8'hFF; unmapped writes SHALL have no effect.
REQ-019 TXDATA read SHALL return 8'h00; STATUS read SHALL return {count[4:0], overflow, full, empty}.
REQ-020 Write to TXDATA with FIFO not full SHALL push wr_data at the tail; count increments by 1.
REQ-021 Write to TXDATA with FIFO full and no simultaneous pop SHALL drop the byte and set overflow (sticky).
REQ-022 Pop SHALL occur at each rising edge where tx_valid=1 and tx_ready=1; head advances, count decrements.
REQ-023 Simultaneous push and pop SHALL both take effect with count unchanged; when full, this push SHALL be accepted and overflow SHALL NOT be set.
REQ-024 When empty, a push SHALL make tx_valid=1 on the following cycle; tx_ready while tx_valid=0 SHALL have no effect.
REQ-025 FIFO SHALL be first-word fall-through: tx_data = entry at head whenever tx_valid=1; tx_data and tx_valid SHALL be stable until popped.
REQ-026 Head/tail pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-027 empty SHALL be (count==0); full SHALL be (count==FIFO_DEPTH); tx_valid SHALL equal !empty.
REQ-028 Any write to STATUS SHALL clear overflow, regardless of data; a simultaneous overflowing TXDATA write is impossible (single address), so no priority is needed.

Reset
REQ-029 Asserting reset SHALL immediately clear head, tail, count and overflow, forcing tx_valid=0 and STATUS=8'h01, without waiting for clk.
REQ-030 RAM contents SHALL NOT be cleared by reset; writes SHALL be ignored while reset=1.
REQ-031 Reset mid-operation SHALL discard all queued FIFO bytes; the first push after reset release SHALL appear as tx_data.

Verification
REQ-032 Vector: reset, address=$FFFC then $FFFD -> rd_data 8'h00 then 8'h02; address=$1234 -> 8'hFF.
REQ-033 RAM: write 8'hA5 to $0010, then next cycle address=$0010 -> rd_data 8'hA5; write to $0FFF/$1000 -> $0FFF holds data, $1000 reads 8'hFF.
REQ-034 FIFO order: tx_ready=0, push 8'h41,8'h42,8'h43 -> STATUS=8'h18; raise tx_ready -> tx_data 41,42,43 on consecutive cycles, then tx_valid=0, STATUS=8'h01.
REQ-035 Full/overflow: tx_ready=0, push 17 bytes 0..16 -> STATUS=8'h86 (count 16, overflow, full); drain yields 0..15; write STATUS -> overflow clears.
REQ-036 Full with concurrent pop: FIFO full, tx_ready=1, push 8'h77 -> count stays 16, overflow stays 0, 8'h77 emerges 16 pops later.
REQ-037 Async reset: FIFO holding 5 bytes, pulse reset between clock edges -> tx_valid falls before next edge, STATUS=8'h01, RAM byte at $0010 preserved.
